// File: rtl/dpll_pkg.sv
// Shared DPLL constants: loop-filter/NCO word widths, zero-offset control value
// and the default NCO centre frequency and clamp window.
package dpll_pkg;

    localparam int CTRL_W     = 20;
    localparam int ACC_W      = 24;
    localparam int CTRL_MID   = 100000;
    localparam int CTRL_SHIFT = 2;

    localparam logic [ACC_W-1:0] CENTER_FCW = 24'h100000;
    localparam logic [ACC_W-1:0] FCW_MIN    = 24'h0FC000;
    localparam logic [ACC_W-1:0] FCW_MAX    = 24'h110000;

endpackage

// File: rtl/dpll_fcw_clamp.sv
// Combinational FCW builder: adds the signed offset to the centre frequency
// and limits the result to the allowed FCW window, flagging any clamp.
module dpll_fcw_clamp
    import dpll_pkg::*;
#(
    parameter int               ACC_W      = dpll_pkg::ACC_W,
    parameter int               CTRL_W     = dpll_pkg::CTRL_W,
    parameter logic [ACC_W-1:0] CENTER_FCW = dpll_pkg::CENTER_FCW,
    parameter logic [ACC_W-1:0] FCW_MIN    = dpll_pkg::FCW_MIN,
    parameter logic [ACC_W-1:0] FCW_MAX    = dpll_pkg::FCW_MAX
) (
    input  logic [CTRL_W+1:0] offset_i,
    output logic [ACC_W-1:0]  fcw_o,
    output logic              sat_o
);

    localparam int SUM_W = ACC_W + 2;
    localparam int OFF_W = CTRL_W + 2;

    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] lo;
    logic signed [SUM_W-1:0] hi;

    // Two guard bits keep the sum's sign and overflow before the compare.
    assign lo  = $signed({2'b00, FCW_MIN});
    assign hi  = $signed({2'b00, FCW_MAX});
    assign sum = $signed({2'b00, CENTER_FCW})
               + $signed({{(SUM_W-OFF_W){offset_i[OFF_W-1]}}, offset_i});

    always_comb begin
        fcw_o = sum[ACC_W-1:0];
        sat_o = 1'b0;
        if (sum > hi) begin
            fcw_o = FCW_MAX;
            sat_o = 1'b1;
        end else if (sum < lo) begin
            fcw_o = FCW_MIN;
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/dpll_nco.sv
// DPLL numerically controlled oscillator: two-stage control word to FCW
// conversion feeding a free-running wrapping phase accumulator.
module dpll_nco
    import dpll_pkg::*;
#(
    parameter int               ACC_W      = dpll_pkg::ACC_W,
    parameter int               CTRL_W     = dpll_pkg::CTRL_W,
    parameter int               CTRL_MID   = dpll_pkg::CTRL_MID,
    parameter int               CTRL_SHIFT = dpll_pkg::CTRL_SHIFT,
    parameter logic [ACC_W-1:0] CENTER_FCW = dpll_pkg::CENTER_FCW,
    parameter logic [ACC_W-1:0] FCW_MIN    = dpll_pkg::FCW_MIN,
    parameter logic [ACC_W-1:0] FCW_MAX    = dpll_pkg::FCW_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              ctrl_valid,
    output logic              ctrl_ready,
    input  logic              freeze,
    output logic [ACC_W-1:0]  fcw_out,
    output logic              sat,
    output logic              nco_out,
    output logic [7:0]        phase_out,
    output logic              tick
);

    localparam int OFF_W = CTRL_W + 2;

    logic                    busy_q;
    logic [OFF_W-1:0]        offset_q;
    logic [ACC_W-1:0]        acc_q;
    logic [ACC_W-1:0]        fcw_q;
    logic                    sat_q;
    logic                    tick_q;

    logic                    accept;
    logic signed [OFF_W-1:0] ctrl_s;
    logic signed [OFF_W-1:0] diff;
    logic signed [OFF_W-1:0] offset_d;
    logic [ACC_W-1:0]        fcw_d;
    logic                    sat_d;
    logic [ACC_W:0]          acc_d;

    assign ctrl_ready = !busy_q && !freeze;
    assign accept     = ctrl_valid && ctrl_ready;

    assign ctrl_s   = $signed({2'b00, ctrl_in});
    assign diff     = ctrl_s - $signed(OFF_W'(CTRL_MID));
    assign offset_d = diff >>> CTRL_SHIFT;

    dpll_fcw_clamp #(
        .ACC_W      (ACC_W),
        .CTRL_W     (CTRL_W),
        .CENTER_FCW (CENTER_FCW),
        .FCW_MIN    (FCW_MIN),
        .FCW_MAX    (FCW_MAX)
    ) u_clamp (
        .offset_i (offset_q),
        .fcw_o    (fcw_d),
        .sat_o    (sat_d)
    );

    // The extra top bit is the wrap carry that becomes next cycle's tick.
    assign acc_d = {1'b0, acc_q} + {1'b0, fcw_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q   <= 1'b0;
            offset_q <= '0;
            acc_q    <= '0;
            fcw_q    <= CENTER_FCW;
            sat_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            busy_q <= accept;
            if (accept) begin
                offset_q <= offset_d;
            end
            if (busy_q) begin
                fcw_q <= fcw_d;
                sat_q <= sat_d;
            end
            acc_q  <= acc_d[ACC_W-1:0];
            tick_q <= acc_d[ACC_W];
        end
    end

    assign fcw_out   = fcw_q;
    assign sat       = sat_q;
    assign tick      = tick_q;
    assign nco_out   = acc_q[ACC_W-1];
    assign phase_out = acc_q[ACC_W-1 -: 8];

endmodule

// File: tb/tb_dpll_nco.sv
// Self-checking bench for dpll_nco: directed scenarios plus randomized traffic
// compared cycle by cycle against an integer-arithmetic reference model.
module tb_dpll_nco;

    localparam longint CENTER = 64'h100000;
    localparam longint FMIN   = 64'h0FC000;
    localparam longint FMAX   = 64'h110000;
    localparam longint MOD    = 64'h1000000;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] ctrl_in;
    logic        ctrl_valid;
    logic        freeze;
    logic        ctrl_ready;
    logic [23:0] fcw_out;
    logic        sat;
    logic        nco_out;
    logic [7:0]  phase_out;
    logic        tick;

    int compared   = 0;
    int mismatched = 0;

    longint mAcc;
    longint mFcw;
    bit     mSat;
    bit     mTick;
    bit     mPend;
    longint pendFcw;
    bit     pendSat;

    dpll_nco dut (
        .clk        (clk),
        .rst        (rst),
        .ctrl_in    (ctrl_in),
        .ctrl_valid (ctrl_valid),
        .ctrl_ready (ctrl_ready),
        .freeze     (freeze),
        .fcw_out    (fcw_out),
        .sat        (sat),
        .nco_out    (nco_out),
        .phase_out  (phase_out),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    // Offset is floor((ctrl - mid) / 4), matching an arithmetic shift right.
    function automatic void refLoad(input int ctrl, output longint fcw, output bit clamped);
        int     d;
        int     off;
        longint raw;
        d = ctrl - 100000;
        if (d >= 0) off = d / 4;
        else        off = -((-d + 3) / 4);
        raw     = CENTER + longint'(off);
        fcw     = raw;
        clamped = 1'b0;
        if (raw > FMAX) begin
            fcw     = FMAX;
            clamped = 1'b1;
        end else if (raw < FMIN) begin
            fcw     = FMIN;
            clamped = 1'b1;
        end
    endfunction

    function automatic bit mReady();
        return !mPend && !freeze;
    endfunction

    function automatic logic [7:0] mPhase();
        return 8'((mAcc >> 16) & 255);
    endfunction

    function automatic logic mNco();
        return 1'((mAcc >> 23) & 1);
    endfunction

    task automatic modelReset();
        mAcc  = 0;
        mFcw  = CENTER;
        mSat  = 1'b0;
        mTick = 1'b0;
        mPend = 1'b0;
    endtask

    // One clock of DUT and model; entered and left between active edges.
    task automatic advance();
        bit     take;
        longint s;
        take = ctrl_valid && mReady() && rst;
        @(posedge clk);
        s     = mAcc + mFcw;
        mTick = (s >= MOD);
        mAcc  = s % MOD;
        if (mPend) begin
            mFcw  = pendFcw;
            mSat  = pendSat;
            mPend = 1'b0;
        end
        if (take) begin
            refLoad(int'(ctrl_in), pendFcw, pendSat);
            mPend = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        ctrl_in    = '0;
        ctrl_valid = 1'b0;
        freeze     = 1'b0;
        rst        = 1'b1;
        #2;
        rst = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        compared += 6;
        if (fcw_out !== 24'h100000) begin mismatched++; $display("[TB] FAIL reset_fcw: got %h expected 100000", fcw_out); end
        if (sat !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_sat: got %b expected 0", sat); end
        if (tick !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_tick: got %b expected 0", tick); end
        if (nco_out !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_nco: got %b expected 0", nco_out); end
        if (phase_out !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_phase: got %h expected 00", phase_out); end
        if (ctrl_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ready: got %b expected 1", ctrl_ready); end
        freeze = 1'b1;
        #1;
        compared++;
        if (ctrl_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ready_freeze: got %b expected 0", ctrl_ready); end
        freeze = 1'b0;
        rst    = 1'b1;
    endtask

    task automatic test_free_run();
        int ticks;
        int highs;
        ticks = 0;
        highs = 0;
        for (int i = 0; i < 64; i++) begin
            advance();
            compared += 3;
            if (tick !== mTick) begin mismatched++; $display("[TB] FAIL freerun_tick[%0d]: got %b expected %b", i, tick, mTick); end
            if (nco_out !== mNco()) begin mismatched++; $display("[TB] FAIL freerun_nco[%0d]: got %b expected %b", i, nco_out, mNco()); end
            if (phase_out !== mPhase()) begin mismatched++; $display("[TB] FAIL freerun_phase[%0d]: got %h expected %h", i, phase_out, mPhase()); end
            if (tick === 1'b1) ticks++;
            if (nco_out === 1'b1) highs++;
        end
        compared += 4;
        if (ticks != 4) begin mismatched++; $display("[TB] FAIL freerun_tick_count: got %0d expected 4", ticks); end
        if (highs != 32) begin mismatched++; $display("[TB] FAIL freerun_high_count: got %0d expected 32", highs); end
        if (fcw_out !== 24'h100000) begin mismatched++; $display("[TB] FAIL freerun_fcw: got %h expected 100000", fcw_out); end
        if (sat !== 1'b0) begin mismatched++; $display("[TB] FAIL freerun_sat: got %b expected 0", sat); end
    endtask

    task automatic test_zero_offset();
        ctrl_in    = 20'd100000;
        ctrl_valid = 1'b1;
        compared++;
        if (ctrl_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL zero_ready_before: got %b expected 1", ctrl_ready); end
        advance();
        ctrl_valid = 1'b0;
        compared += 2;
        if (ctrl_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_ready_busy: got %b expected 0", ctrl_ready); end
        if (fcw_out !== 24'h100000) begin mismatched++; $display("[TB] FAIL zero_fcw_n: got %h expected 100000", fcw_out); end
        advance();
        compared += 3;
        if (ctrl_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL zero_ready_after: got %b expected 1", ctrl_ready); end
        if (fcw_out !== 24'h100000) begin mismatched++; $display("[TB] FAIL zero_fcw_n1: got %h expected 100000", fcw_out); end
        if (sat !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_sat: got %b expected 0", sat); end
    endtask

    task automatic test_positive();
        ctrl_in    = 20'd200000;
        ctrl_valid = 1'b1;
        advance();
        ctrl_valid = 1'b0;
        advance();
        compared += 2;
        if (fcw_out !== 24'h1061A8) begin mismatched++; $display("[TB] FAIL pos_fcw: got %h expected 1061a8", fcw_out); end
        if (sat !== 1'b0) begin mismatched++; $display("[TB] FAIL pos_sat: got %b expected 0", sat); end
        for (int i = 0; i < 24; i++) begin
            advance();
            compared += 2;
            if (phase_out !== mPhase()) begin mismatched++; $display("[TB] FAIL pos_phase[%0d]: got %h expected %h", i, phase_out, mPhase()); end
            if (tick !== mTick) begin mismatched++; $display("[TB] FAIL pos_tick[%0d]: got %b expected %b", i, tick, mTick); end
        end
    endtask

    task automatic test_clamp();
        logic [19:0] words [3] = '{20'hFFFFF, 20'h00000, 20'd100000};
        logic [23:0] fcws  [3] = '{24'h110000, 24'h0FC000, 24'h100000};
        logic        sats  [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            ctrl_in    = words[i];
            ctrl_valid = 1'b1;
            advance();
            ctrl_valid = 1'b0;
            advance();
            compared += 2;
            if (fcw_out !== fcws[i]) begin mismatched++; $display("[TB] FAIL clamp_fcw[%0d]: got %h expected %h", i, fcw_out, fcws[i]); end
            if (sat !== sats[i]) begin mismatched++; $display("[TB] FAIL clamp_sat[%0d]: got %b expected %b", i, sat, sats[i]); end
        end
    endtask

    task automatic test_back_to_back();
        ctrl_in    = 20'd150000;
        ctrl_valid = 1'b1;
        advance();
        ctrl_in = 20'd60000;
        compared++;
        if (ctrl_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_ready_n: got %b expected 0", ctrl_ready); end
        advance();
        compared += 2;
        if (fcw_out !== 24'h1030D4) begin mismatched++; $display("[TB] FAIL b2b_fcw_a: got %h expected 1030d4", fcw_out); end
        if (ctrl_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_ready_n1: got %b expected 1", ctrl_ready); end
        advance();
        ctrl_valid = 1'b0;
        compared += 2;
        if (fcw_out !== 24'h1030D4) begin mismatched++; $display("[TB] FAIL b2b_fcw_hold: got %h expected 1030d4", fcw_out); end
        if (ctrl_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_ready_n2: got %b expected 0", ctrl_ready); end
        advance();
        compared += 2;
        if (fcw_out !== 24'h0FD8F0) begin mismatched++; $display("[TB] FAIL b2b_fcw_b: got %h expected 0fd8f0", fcw_out); end
        if (sat !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_sat_b: got %b expected 0", sat); end
    endtask

    task automatic test_freeze();
        ctrl_in    = 20'd180000;
        ctrl_valid = 1'b1;
        advance();
        freeze  = 1'b1;
        ctrl_in = 20'd20000;
        #1;
        compared++;
        if (ctrl_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL frz_ready: got %b expected 0", ctrl_ready); end
        advance();
        compared++;
        if (fcw_out !== 24'h104E20) begin mismatched++; $display("[TB] FAIL frz_inflight_fcw: got %h expected 104e20", fcw_out); end
        for (int i = 0; i < 5; i++) begin
            advance();
            compared += 3;
            if (ctrl_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL frz_ready_hold[%0d]: got %b expected 0", i, ctrl_ready); end
            if (fcw_out !== 24'h104E20) begin mismatched++; $display("[TB] FAIL frz_fcw_hold[%0d]: got %h expected 104e20", i, fcw_out); end
            if (phase_out !== mPhase()) begin mismatched++; $display("[TB] FAIL frz_phase[%0d]: got %h expected %h", i, phase_out, mPhase()); end
        end
        freeze = 1'b0;
        #1;
        compared++;
        if (ctrl_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL frz_ready_release: got %b expected 1", ctrl_ready); end
        advance();
        ctrl_valid = 1'b0;
        advance();
        compared += 2;
        if (fcw_out !== 24'h0FC000) begin mismatched++; $display("[TB] FAIL frz_held_word_fcw: got %h expected 0fc000", fcw_out); end
        if (sat !== 1'b1) begin mismatched++; $display("[TB] FAIL frz_held_word_sat: got %b expected 1", sat); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 0) ctrl_in = 20'($urandom_range(60000, 140000));
            else                           ctrl_in = 20'($urandom_range(0, 1048575));
            ctrl_valid = 1'($urandom_range(0, 1));
            freeze     = ($urandom_range(0, 7) == 0);
            #1;
            compared++;
            if (ctrl_ready !== mReady()) begin mismatched++; $display("[TB] FAIL rand_ready[%0d]: got %b expected %b", i, ctrl_ready, mReady()); end
            advance();
            compared += 5;
            if (fcw_out !== 24'(mFcw)) begin mismatched++; $display("[TB] FAIL rand_fcw[%0d]: got %h expected %h", i, fcw_out, 24'(mFcw)); end
            if (sat !== mSat) begin mismatched++; $display("[TB] FAIL rand_sat[%0d]: got %b expected %b", i, sat, mSat); end
            if (tick !== mTick) begin mismatched++; $display("[TB] FAIL rand_tick[%0d]: got %b expected %b", i, tick, mTick); end
            if (nco_out !== mNco()) begin mismatched++; $display("[TB] FAIL rand_nco[%0d]: got %b expected %b", i, nco_out, mNco()); end
            if (phase_out !== mPhase()) begin mismatched++; $display("[TB] FAIL rand_phase[%0d]: got %h expected %h", i, phase_out, mPhase()); end
        end
        ctrl_valid = 1'b0;
        freeze     = 1'b0;
        advance();
        advance();
    endtask

    task automatic test_reset_mid();
        ctrl_in    = 20'd200000;
        ctrl_valid = 1'b1;
        advance();
        ctrl_valid = 1'b0;
        rst        = 1'b0;
        modelReset();
        #1;
        compared += 3;
        if (fcw_out !== 24'h100000) begin mismatched++; $display("[TB] FAIL rstmid_fcw: got %h expected 100000", fcw_out); end
        if (tick !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_tick: got %b expected 0", tick); end
        if (phase_out !== 8'h00) begin mismatched++; $display("[TB] FAIL rstmid_phase: got %h expected 00", phase_out); end
        repeat (2) @(negedge clk);
        compared += 4;
        if (fcw_out !== 24'h100000) begin mismatched++; $display("[TB] FAIL rstmid_fcw_hold: got %h expected 100000", fcw_out); end
        if (sat !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_sat: got %b expected 0", sat); end
        if (nco_out !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_nco: got %b expected 0", nco_out); end
        if (ctrl_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rstmid_ready: got %b expected 1", ctrl_ready); end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            advance();
            compared += 2;
            if (fcw_out !== 24'h100000) begin mismatched++; $display("[TB] FAIL rstmid_discard[%0d]: got %h expected 100000", i, fcw_out); end
            if (phase_out !== mPhase()) begin mismatched++; $display("[TB] FAIL rstmid_phase_run[%0d]: got %h expected %h", i, phase_out, mPhase()); end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_zero_offset();
        test_positive();
        test_clamp();
        test_back_to_back();
        test_freeze();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
